id_issue_ctrl: RTL
==================

# id_issue_ctrl

Issue controller for the ID stage of the MIPS pipeline. It decides each cycle whether the instruction held in the IF/ID register may issue to EX. It stalls on load-use hazards, on HI/LO-unit occupancy from multi-cycle MULT/DIV, and on EX backpressure, and it discards the wrong-path instruction after a flush. It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
- DIV_CYCLES, 32: cycles the HI/LO unit stays busy after DIV/DIVU issues (≥1).
- MUL_CYCLES, 2: cycles the HI/LO unit stays busy after MULT/MULTU issues (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- if_valid  in  1  IF/ID register holds a valid instruction.
- if_instr  in  32  instruction word. Fields: opcode [31:26], rs [25:21], rt [20:16], funct [5:0].
- ex_ready  in  1  EX accepts an instruction this cycle.
- ex_is_load  in  1  instruction currently in EX is a load.
- ex_wreg  in  5  destination register of the instruction in EX.
- flush  in  1  branch/exception flush from a later stage.
- id_ready  out  1  the IF/ID contents are consumed this cycle, so IF may advance.
- id_issue  out  1  the instruction moves to EX this cycle.
- hilo_busy  out  1  HI/LO busy counter is non-zero.
- stall_cause  out  2  0 none, 1 load-use, 2 HI/LO busy, 3 EX backpressure.
- stall_cycles  out  32  saturating count of stalled cycles.

## Operation
- Source-use decode from if_instr:
  - uses_rs = 0 for J (000010), JAL (000011), LUI (001111), and for SPECIAL funct SLL/SRL/SRA (000000/000010/000011) or MFHI/MFLO (010000/010010). uses_rs = 1 otherwise.
  - uses_rt = 1 for SPECIAL except MFHI, MFLO, JR (001000) and JALR (001001). uses_rt = 1 for BEQ (000100), BNE (000101), SB (101000), SH (101001) and SW (101011). uses_rt = 0 otherwise.
- Load-use hazard: ex_is_load && ex_wreg≠0 && ((uses_rs && rs==ex_wreg) || (uses_rt && rt==ex_wreg)). Register 0 never causes a hazard.
- HI/LO class: SPECIAL funct MFHI, MTHI (010001), MFLO, MTLO (010011), MULT (011000), MULTU (011001), DIV (011010), DIVU (011011). A HI/LO-class instruction is blocked while busy_cnt≠0.
- busy_cnt width is clog2(max(DIV_CYCLES,MUL_CYCLES)+1).
  - On issue of DIV/DIVU it loads DIV_CYCLES.
  - On issue of MULT/MULTU it loads MUL_CYCLES.
  - Otherwise it decrements when non-zero.
  - Issue while busy is impossible, so load and decrement never conflict.
- State machine, 2 states:
  - RUN: normal issue.
  - DRAIN: entered on the cycle after flush is sampled high. In DRAIN, a valid IF/ID instruction is discarded (id_ready=1, id_issue=0). The state returns to RUN after one cycle, or stays in DRAIN if flush is high again.
- Issue and ready:
  - id_issue = if_valid && state==RUN && !flush && ex_ready && !lu_hazard && !hilo_block.
  - id_ready = id_issue || !if_valid || state==DRAIN || flush. A flush also discards the current IF/ID contents.
- stall_cause priority, evaluated only when if_valid && state==RUN && !flush:
  - load-use (1) > HI/LO (2) > backpressure (3). Otherwise 0.
- stall_cycles increments when stall_cause≠0 and saturates at 0xFFFF_FFFF.
- flush does not clear busy_cnt. An issued MULT/DIV runs to completion; result suppression is EX's responsibility.

## Timing
- Reset (resetn=0 at an edge): state=RUN, busy_cnt=0, stall_cycles=0.
- While resetn=0, the combinational outputs are forced to id_issue=0, id_ready=0, stall_cause=0, and hilo_busy=0.
- id_issue, id_ready and stall_cause are combinational from the inputs and current state, with zero-cycle latency.
- hilo_busy and stall_cycles are registered.
- After a DIV issues in cycle T, hilo_busy is 1 from T+1 through T+DIV_CYCLES. A HI/LO-class instruction may issue at T+DIV_CYCLES+1 at the earliest.
- A load-use stall lasts exactly as long as the matching load sits in EX, normally 1 cycle.
- If flush is high in the same cycle as a potential issue, flush wins: id_issue=0.
- Reset asserted mid-DIV clears busy_cnt on that edge.

## Test plan
- ADD $3,$1,$2 with ex_is_load=1, ex_wreg=2 → id_issue=0, stall_cause=1, stall_cycles +1. Next cycle with ex_is_load=0 → id_issue=1.
- LW $0 in EX (ex_wreg=0) followed by ADD $4,$0,$0 → no stall, id_issue=1.
- DIV $1,$2 issued at T, then MFLO presented → stall_cause=2 for 32 cycles. MFLO issues at T+33. ADD during busy issues without stall.
- flush=1 with a valid instruction → id_issue=0, id_ready=1. The next cycle (DRAIN) discards another valid instruction; the third cycle issues normally.
- ex_ready=0 with a hazard-free instruction → stall_cause=3, id_ready=0. A simultaneous load-use hazard reports cause 1.
- Preload stall_cycles to 0xFFFF_FFFE via a sustained stall → it saturates at 0xFFFF_FFFF. Then resetn=0 for one edge → stall_cycles=0, busy_cnt=0, state=RUN.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: ID-stage issue controller for the MIPS pipeline.
//
// Each cycle this block decides whether the instruction in the IF/ID register
// may move to EX. The instruction stalls when:
//   - it reads a register that a load in EX is about to write (load-use),
//   - it touches HI/LO while a MULT/DIV is still running, or
//   - EX is not ready to accept it (backpressure).
// After a flush, the next instruction is on the wrong path and is discarded.
// The block also keeps a saturating count of stalled cycles.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   resetn       in   synchronous active-low reset
//   if_valid     in   IF/ID holds a valid instruction
//   if_instr     in   instruction word in IF/ID
//   ex_ready     in   EX accepts an instruction this cycle
//   ex_is_load   in   instruction in EX is a load
//   ex_wreg      in   destination register of the instruction in EX
//   flush        in   branch/exception flush from a later stage
//   id_ready     out  IF/ID contents are consumed this cycle
//   id_issue     out  instruction moves to EX this cycle
//   hilo_busy    out  HI/LO unit is busy (registered)
//   stall_cause  out  0 none, 1 load-use, 2 HI/LO busy, 3 EX backpressure
//   stall_cycles out  saturating count of stalled cycles (registered)
module id_issue_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic        ex_ready,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_wreg,
    input  logic        flush,
    output logic        id_ready,
    output logic        id_issue,
    output logic        hilo_busy,
    output logic [1:0]  stall_cause,
    output logic [31:0] stall_cycles
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpJ       = 6'b000010;
    localparam logic [5:0] OpJal     = 6'b000011;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpBne     = 6'b000101;
    localparam logic [5:0] OpLui     = 6'b001111;
    localparam logic [5:0] OpSb      = 6'b101000;
    localparam logic [5:0] OpSh      = 6'b101001;
    localparam logic [5:0] OpSw      = 6'b101011;

    localparam logic [5:0] FnSll   = 6'b000000;
    localparam logic [5:0] FnSrl   = 6'b000010;
    localparam logic [5:0] FnSra   = 6'b000011;
    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnJalr  = 6'b001001;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] busy_q, busy_d;
    logic [31:0]     stall_q, stall_d;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       is_special;
    logic       uses_rs;
    logic       uses_rt;
    logic       hilo_class;
    logic       is_div;
    logic       is_mul;
    logic       lu_hazard;
    logic       hilo_block;
    logic       eligible;

    assign opcode     = if_instr[31:26];
    assign rs         = if_instr[25:21];
    assign rt         = if_instr[20:16];
    assign funct      = if_instr[5:0];
    assign is_special = (opcode == OpSpecial);

    // Source-register usage decode
    always_comb begin
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        if (is_special) begin
            if (funct inside {FnSll, FnSrl, FnSra, FnMfhi, FnMflo}) begin
                uses_rs = 1'b0;
            end
            uses_rt = !(funct inside {FnMfhi, FnMflo, FnJr, FnJalr});
        end else begin
            if (opcode inside {OpJ, OpJal, OpLui}) begin
                uses_rs = 1'b0;
            end
            uses_rt = opcode inside {OpBeq, OpBne, OpSb, OpSh, OpSw};
        end
    end

    assign hilo_class = is_special && (funct inside {FnMfhi, FnMthi, FnMflo, FnMtlo,
                                                      FnMult, FnMultu, FnDiv, FnDivu});
    assign is_div     = is_special && (funct inside {FnDiv, FnDivu});
    assign is_mul     = is_special && (funct inside {FnMult, FnMultu});

    // $0 is hardwired, so a load targeting it can never create a hazard
    assign lu_hazard  = ex_is_load && (ex_wreg != 5'd0) &&
                        ((uses_rs && (rs == ex_wreg)) || (uses_rt && (rt == ex_wreg)));
    assign hilo_block = hilo_class && (busy_q != '0);

    // Only a live instruction on the correct path can stall
    assign eligible = resetn && if_valid && (state_q == StRun) && !flush;

    always_comb begin
        id_issue = eligible && ex_ready && !lu_hazard && !hilo_block;
        id_ready = resetn && (id_issue || !if_valid || (state_q == StDrain) || flush);

        stall_cause = 2'd0;
        if (eligible) begin
            if (lu_hazard) begin
                stall_cause = 2'd1;
            end else if (hilo_block) begin
                stall_cause = 2'd2;
            end else if (!ex_ready) begin
                stall_cause = 2'd3;
            end
        end
    end

    // A flush always leaves the next cycle in DRAIN; otherwise return to RUN
    always_comb begin
        state_d = flush ? StDrain : StRun;
    end

    // Issue can only happen with busy_q == 0 for HI/LO ops, so load and
    // decrement never collide.
    always_comb begin
        busy_d = busy_q;
        if (id_issue && is_div) begin
            busy_d = CntW'(DIV_CYCLES);
        end else if (id_issue && is_mul) begin
            busy_d = CntW'(MUL_CYCLES);
        end else if (busy_q != '0) begin
            busy_d = busy_q - 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if ((stall_cause != 2'd0) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StRun;
            busy_q  <= '0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign hilo_busy    = resetn && (busy_q != '0);
    assign stall_cycles = stall_q;

endmodule
